// File: rtl/ewb_queue_pkg.sv
// Shared types for the eviction write buffer queue.
// Line, word and controller-state definitions.
package ewb_queue_pkg;

  localparam int LINE_OFFSET_W = 4;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } ewb_state_t;

endpackage

// File: rtl/ewb_entry_array.sv
// Tag/line storage for the write buffer with occupancy-aware matching.
// Newest matching entry wins on both the read and the eviction lookup.
module ewb_entry_array
  import ewb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 12,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic [PTR_W-1:0] head,
  input  logic [CNT_W-1:0] count,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [127:0]     wr_data,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [127:0]     rd_data,
  input  logic [TAG_W-1:0] ev_tag,
  input  logic             ev_skip_head,
  output logic             ev_hit,
  output logic [PTR_W-1:0] ev_idx,
  output logic [TAG_W-1:0] head_tag,
  output logic [127:0]     head_data
);

  logic [TAG_W-1:0] tags  [DEPTH];
  lc3b_line         lines [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] rd_match;
  logic [DEPTH-1:0] ev_match;
  logic [PTR_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_data;
    end
  end

  // An entry is live when its distance from head is below count
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PTR_W-1:0] age;
    assign age         = PTR_W'(g) - head;
    assign valid[g]    = {1'b0, age} < count;
    assign rd_match[g] = valid[g] && (tags[g] == rd_tag);
    assign ev_match[g] = valid[g] && (tags[g] == ev_tag) &&
                         !(ev_skip_head && (PTR_W'(g) == head));
  end

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    ev_hit  = 1'b0;
    ev_idx  = '0;
    idx     = '0;
    for (int a = 0; a < DEPTH; a++) begin
      idx = head + PTR_W'(a);
      if (rd_match[idx]) begin
        rd_hit  = 1'b1;
        rd_data = lines[idx];
      end
      if (ev_match[idx]) begin
        ev_hit = 1'b1;
        ev_idx = idx;
      end
    end
  end

  assign head_tag  = tags[head];
  assign head_data = lines[head];

endmodule

// File: rtl/ewb_queue.sv
// Multi-entry eviction write buffer between L2 and pmem.
// Reads win over draining; hits forward, repeat evictions coalesce.
module ewb_queue
  import ewb_queue_pkg::*;
#(
  parameter  int DEPTH    = 4,
  parameter  int OFFSET_W = LINE_OFFSET_W,
  localparam int TAG_W    = 16 - OFFSET_W,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evict_valid,
  input  logic [15:0]      evict_addr,
  input  logic [127:0]     evict_data,
  output logic             evict_ready,
  input  logic             l2_read,
  input  logic [15:0]      l2_addr,
  output logic [127:0]     l2_rdata,
  output logic             l2_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [15:0]      pmem_address,
  output logic [127:0]     pmem_wdata,
  input  logic [127:0]     pmem_rdata,
  input  logic             pmem_resp,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  ewb_state_t       state, state_n;
  logic [PTR_W-1:0] head, tail;
  logic             accept, append, pop;
  logic             rd_hit, ev_hit;
  logic [PTR_W-1:0] ev_idx;
  logic [TAG_W-1:0] head_tag;
  lc3b_line         rd_data, head_data;
  logic             unused_low;

  assign unused_low  = ^{evict_addr[OFFSET_W-1:0],
                         l2_addr[OFFSET_W-1:0]};
  assign full        = count == CNT_W'(DEPTH);
  assign empty       = count == '0;
  assign evict_ready = !full;
  assign accept      = evict_valid && !full;
  assign append      = accept && !ev_hit;
  assign pop         = (state == WRITE) && pmem_resp;

  ewb_entry_array #(
    .DEPTH(DEPTH),
    .TAG_W(TAG_W)
  ) u_array (
    .clk         (clk),
    .head        (head),
    .count       (count),
    .wr_en       (accept),
    .wr_idx      (ev_hit ? ev_idx : tail),
    .wr_tag      (evict_addr[15:OFFSET_W]),
    .wr_data     (evict_data),
    .rd_tag      (l2_addr[15:OFFSET_W]),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data),
    .ev_tag      (evict_addr[15:OFFSET_W]),
    .ev_skip_head(state == WRITE),
    .ev_hit      (ev_hit),
    .ev_idx      (ev_idx),
    .head_tag    (head_tag),
    .head_data   (head_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (append) tail <= tail + PTR_W'(1);
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(append) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_n      = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {l2_addr[15:OFFSET_W], {OFFSET_W{1'b0}}};
    pmem_wdata   = '0;
    l2_resp      = 1'b0;
    l2_rdata     = '0;
    case (state)
      IDLE: begin
        if (l2_read && rd_hit) begin
          l2_resp  = 1'b1;
          l2_rdata = rd_data;
        end else if (l2_read) begin
          state_n = READ;
        end else if (!empty) begin
          state_n = WRITE;
        end
      end
      READ: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          l2_resp  = 1'b1;
          l2_rdata = pmem_rdata;
          state_n  = IDLE;
        end
      end
      WRITE: begin
        pmem_write   = 1'b1;
        pmem_address = {head_tag, {OFFSET_W{1'b0}}};
        pmem_wdata   = head_data;
        // A miss waits for the write; a hit never needs pmem
        if (l2_read && rd_hit) begin
          l2_resp  = 1'b1;
          l2_rdata = rd_data;
        end
        if (pmem_resp) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ewb_queue.sv
// Self-checking bench for ewb_queue: queue-level reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_ewb_queue;

  localparam int DEPTH    = 4;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = 16 - OFFSET_W;
  localparam int CNT_W    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             evict_valid;
  logic [15:0]      evict_addr;
  logic [127:0]     evict_data;
  logic             evict_ready;
  logic             l2_read;
  logic [15:0]      l2_addr;
  logic [127:0]     l2_rdata;
  logic             l2_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic [15:0]      pmem_address;
  logic [127:0]     pmem_wdata;
  logic [127:0]     pmem_rdata = '0;
  logic             pmem_resp = 1'b0;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;

  ewb_queue #(.DEPTH(DEPTH), .OFFSET_W(OFFSET_W)) dut (
    .clk(clk), .reset(reset),
    .evict_valid(evict_valid), .evict_addr(evict_addr),
    .evict_data(evict_data), .evict_ready(evict_ready),
    .l2_read(l2_read), .l2_addr(l2_addr),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of queued lines, oldest first
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [127:0]     data;
  } ent_t;

  ent_t q[$];
  int   m_mode = 0;   // 0 idle, 1 reading pmem, 2 writing head
  int   m_wait = 0;   // cycles the current pmem access has been up
  bit   m_resp = 1'b0;
  bit   armed  = 1'b0;

  function automatic int newest(logic [TAG_W-1:0] t, bit skip_head);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].tag == t && !(skip_head && i == 0)) return i;
    return -1;
  endfunction

  int mh, mj, nm;
  bit macc, mpop;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_mode = 0;
      m_wait = 0;
      m_resp = 1'b0;
      armed  = 1'b1;
    end else if (armed) begin
      mh     = newest(l2_addr[15:OFFSET_W], 1'b0);
      m_resp = (m_mode == 1) ? pmem_resp : (l2_read && mh >= 0);
      mpop   = (m_mode == 2) && pmem_resp;
      macc   = evict_valid && (q.size() < DEPTH);
      nm     = m_mode;
      if (m_mode == 0) begin
        if (l2_read && mh < 0) nm = 1;
        else if (!l2_read && q.size() > 0) nm = 2;
      end else if (pmem_resp) begin
        nm = 0;
      end
      if (macc) begin
        mj = newest(evict_addr[15:OFFSET_W], m_mode == 2);
        if (mj >= 0) q[mj].data = evict_data;
        else q.push_back('{evict_addr[15:OFFSET_W], evict_data});
      end
      if (mpop) void'(q.pop_front());
      m_wait = (nm != 0 && nm == m_mode) ? m_wait + 1 : 0;
      m_mode = nm;
    end
  end

  // pmem responder: latency fixed for directed tests, random otherwise
  int fixed_lat = 3;
  int lat_cur   = 1;

  always @(posedge clk) begin
    #1;
    if (m_mode != 0 && m_wait == 0)
      lat_cur = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
    pmem_resp  = (m_mode != 0) && (m_wait + 1 >= lat_cur);
    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    int           h;
    logic         e_resp;
    logic [127:0] e_rd, e_wd;
    logic [15:0]  e_addr;
    if (armed) begin
      h      = newest(l2_addr[15:OFFSET_W], 1'b0);
      e_resp = (m_mode == 1) ? pmem_resp : (l2_read && h >= 0);
      e_rd   = '0;
      if (e_resp) e_rd = (m_mode == 1) ? pmem_rdata : q[h].data;
      e_addr = {l2_addr[15:OFFSET_W], {OFFSET_W{1'b0}}};
      e_wd   = '0;
      if (m_mode == 2) begin
        e_addr = {q[0].tag, {OFFSET_W{1'b0}}};
        e_wd   = q[0].data;
      end
      chk("count", count, q.size());
      chk("empty", empty, q.size() == 0);
      chk("full", full, q.size() == DEPTH);
      chk("evict_ready", evict_ready, q.size() != DEPTH);
      chk("pmem_read", pmem_read, m_mode == 1);
      chk("pmem_write", pmem_write, m_mode == 2);
      chk("pmem_address", pmem_address, e_addr);
      chk("pmem_wdata", pmem_wdata, e_wd);
      chk("l2_resp", l2_resp, e_resp);
      chk("l2_rdata", l2_rdata, e_rd);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(string name);
    int c = 0;
    #1;
    while (!(empty && !pmem_write && !pmem_read) && c < 100) begin
      tick;
      #1;
      c++;
    end
    chk({name, "_idle_timeout"}, c < 100, 1'b1);
  endtask

  task automatic push(logic [15:0] a, logic [127:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
  endtask

  localparam logic [127:0] LA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] LB = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  localparam logic [127:0] LC = 128'hCCCC_0001_CCCC_0002_CCCC_0003_CCCC_0004;
  localparam logic [127:0] LD = 128'hDDDD_0001_DDDD_0002_DDDD_0003_DDDD_0004;

  initial begin
    logic [15:0]  got [4];
    logic [127:0] rdat;
    int           n, c;

    reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
    l2_read = 1'b0; l2_addr = '0;
    repeat (2) tick;
    reset = 1'b0;
    #1;
    chk("rst_evict_ready", evict_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_l2_resp", l2_resp, 1'b0);

    // Fill to capacity then drain in order
    for (int k = 0; k < 4; k++) begin
      push(16'(16'h1000 * (k + 1)), {4{32'(k + 1)}});
      tick;
    end
    evict_valid = 1'b0;
    #1;
    chk("fill_count", count, 4);
    chk("fill_full", full, 1'b1);
    chk("fill_ready", evict_ready, 1'b0);
    chk("fill_first_addr", pmem_address, 16'h1000);
    n = 0; c = 0;
    while (!(empty && !pmem_write) && c < 60) begin
      if (pmem_write && pmem_resp && n < 4) begin
        got[n] = pmem_address;
        n++;
      end
      tick;
      #1;
      c++;
    end
    chk("drain_n", n, 4);
    for (int k = 0; k < 4; k++)
      chk("drain_order", got[k], 16'(16'h1000 * (k + 1)));
    chk("drain_empty", empty, 1'b1);

    // Forward a queued line to a same-line read
    wait_idle("fwd");
    push(16'h1230, LA);
    tick;
    evict_valid = 1'b0;
    l2_read = 1'b1; l2_addr = 16'h1238;
    #1;
    chk("fwd_resp", l2_resp, 1'b1);
    chk("fwd_data", l2_rdata, LA);
    chk("fwd_no_pmem_read", pmem_read, 1'b0);
    tick;
    l2_read = 1'b0;

    // Coalesce into a waiting entry
    wait_idle("coal");
    push(16'h5000, LA);
    tick;
    push(16'h5004, LB);
    tick;
    evict_valid = 1'b0;
    #1;
    chk("coal_count", count, 1);
    chk("coal_write", pmem_write, 1'b1);
    chk("coal_addr", pmem_address, 16'h5000);
    chk("coal_wdata", pmem_wdata, LB);

    // Same line evicted while its older copy is being written
    wait_idle("inflight");
    push(16'h1000, LD);
    tick;
    evict_valid = 1'b0;
    tick;
    push(16'h1000, LC);
    tick;
    evict_valid = 1'b0;
    l2_read = 1'b1; l2_addr = 16'h1000;
    #1;
    chk("inflight_count", count, 2);
    chk("inflight_resp", l2_resp, 1'b1);
    chk("inflight_data", l2_rdata, LC);
    tick;
    l2_read = 1'b0;

    // Miss read takes priority over draining
    wait_idle("miss");
    push(16'h8000, LA);
    tick;
    push(16'h9000, LB);
    l2_read = 1'b1; l2_addr = 16'h7000;
    tick;
    evict_valid = 1'b0;
    #1;
    chk("miss_read", pmem_read, 1'b1);
    chk("miss_no_write", pmem_write, 1'b0);
    chk("miss_addr", pmem_address, 16'h7000);
    c = 0;
    while (!l2_resp && c < 20) begin
      tick;
      #1;
      c++;
    end
    chk("miss_resp_timeout", c < 20, 1'b1);
    rdat = pmem_rdata;
    chk("miss_data", l2_rdata, rdat);
    tick;
    l2_read = 1'b0;
    c = 0;
    #1;
    while (!pmem_write && c < 20) begin
      tick;
      #1;
      c++;
    end
    chk("miss_drain_timeout", c < 20, 1'b1);
    chk("miss_drain_addr", pmem_address, 16'h8000);

    // Reset in the middle of a write
    wait_idle("rstw");
    push(16'hA000, LA);
    tick;
    push(16'hB000, LB);
    tick;
    push(16'hC000, LC);
    tick;
    evict_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstw_pre_count", count, 3);
    chk("rstw_pre_write", pmem_write, 1'b1);
    tick;
    reset = 1'b0;
    #1;
    chk("rstw_write", pmem_write, 1'b0);
    chk("rstw_count", count, 0);
    chk("rstw_empty", empty, 1'b1);
    chk("rstw_ready", evict_ready, 1'b1);

    // Random traffic over a small tag pool
    fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 399) == 0);
      evict_valid = ($urandom_range(0, 2) == 0);
      evict_addr  = {12'(12'h100 + $urandom_range(0, 5)), 4'($urandom)};
      evict_data  = {$urandom, $urandom, $urandom, $urandom};
      if (!(l2_read && !m_resp)) begin
        l2_read = ($urandom_range(0, 3) == 0);
        l2_addr = {12'(12'h100 + $urandom_range(0, 5)), 4'($urandom)};
      end
      tick;
    end
    reset = 1'b0; evict_valid = 1'b0; l2_read = 1'b0;
    repeat (40) tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ewb_queue.md
# ewb_queue

Multi-entry eviction write buffer between the L2 cache and physical memory, the parametrised successor to the single-entry EWB controller. It queues up to DEPTH dirty-line evictions with their data and drains them to pmem in FIFO order when pmem is otherwise idle. L2 miss reads take priority over draining. Reads that hit a queued line are forwarded from the buffer. Evictions to a line already queued are coalesced in place.

## Interface
Parameters:
- DEPTH, 4: number of line entries; power of two, 2..16.
- OFFSET_W, 4: line-offset bits; lines are 2^OFFSET_W bytes, giving 128-bit lines.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- evict_valid  in  1  L2 presents a dirty victim.
- evict_addr  in  16  victim address (lc3b_word).
- evict_data  in  128  victim line (lc3b_line).
- evict_ready  out  1  entry can be accepted; equals !full.
- l2_read  in  1  L2 miss read request, held until l2_resp.
- l2_addr  in  16  read address.
- l2_rdata  out  128  read data, valid with l2_resp.
- l2_resp  out  1  read complete, one cycle per request.
- pmem_read  out  1  pmem read strobe.
- pmem_write  out  1  pmem write strobe.
- pmem_address  out  16  line-aligned address, {addr[15:OFFSET_W], 0}.
- pmem_wdata  out  128  head-entry data.
- pmem_rdata  in  128  pmem read data.
- pmem_resp  in  1  pmem transaction complete.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage: circular buffer with head (oldest), tail and count registers. Each entry holds a tag addr[15:OFFSET_W] and a line. Pointers wrap modulo DEPTH.
- Accept: on evict_valid && evict_ready:
  - If the tag matches a valid entry that is not the in-flight head, overwrite that entry's data. Count is unchanged.
  - Otherwise write the entry at tail, increment tail, and increment count.
- Lookup is combinational on l2_addr tag against all valid entries. On multiple matches (possible only with the in-flight head), the newest entry wins.
- States:
  - IDLE
    - l2_read && hit: l2_resp=1 and l2_rdata=entry data this cycle. Stay in IDLE.
    - l2_read && miss: go to READ.
    - No l2_read and count>0: go to WRITE.
    - Otherwise stay.
  - READ: pmem_read=1, pmem_address=aligned l2_addr. On pmem_resp: l2_resp=1, l2_rdata=pmem_rdata, go to IDLE.
  - WRITE: pmem_write=1, pmem_address=aligned head tag, pmem_wdata=head data. On pmem_resp: pop head (head+1, count-1), go to IDLE.
  - Default/illegal state goes to IDLE.
- l2_read during WRITE:
  - Hits are still forwarded immediately.
  - Misses wait for the write to finish (no preemption of pmem).
- Accept and pop in the same cycle: count unchanged, both pointers advance.
- Unasserted outputs are driven to 0. In IDLE, pmem_address is the aligned l2_addr.

## Timing
- Reset state: state=IDLE, head=tail=count=0. Outputs: evict_ready=1, empty=1, full=0, pmem_read=0, pmem_write=0, l2_resp=0.
- Reset mid-transaction:
  - Queued entries and any in-flight pmem access are abandoned.
  - Strobes drop in the cycle after reset is sampled.
- An accepted eviction is visible to lookup and drain on the next cycle.
- Hit latency: 0 cycles (l2_resp in the same cycle as l2_read).
- Miss latency: 1 cycle plus the pmem latency (IDLE to READ, then resp).
- Drain begins 1 cycle after the queue becomes non-empty while l2_read is low.
- When full, evict_ready=0 even if a pop completes that cycle (no bypass). The slot becomes acceptable on the next cycle.
- Strobes are held constant with stable address and data until pmem_resp.

## Structure
- lc3b_types package:
  - Add lc3b_line (128 bits).
  - Add ewb_state_t enum {IDLE, READ, WRITE}.
  - Add constant LINE_OFFSET_W=4.
- Sub-module ewb_entry_array:
  - Tag/data registers, valid-by-pointer range, and tag-match vector.
  - Newest-match priority select relative to tail.
- Top module holds the FSM, pointers, count and output muxing.

## Test plan
- Reset, then push 4 evictions (0x1000, 0x2000, 0x3000, 0x4000) with DEPTH=4 → full=1, evict_ready=0, count=4. Drains in order, each pmem_write held 3 cycles until pmem_resp, address 0x1000 first. Ends with empty=1.
- Queue 0x1230 with data A, then l2_read at 0x1238 → same-cycle l2_resp, l2_rdata=A, no pmem_read.
- Queue 0x5000 with data A, then evict 0x5004 with data B → count stays 1; the drain writes B to 0x5000.
- While WRITE of 0x1000 is in flight, evict 0x1000 with data C → new entry appended, count=2. Then l2_read 0x1000 returns C.
- With entries queued and IDLE, assert l2_read miss 0x7000 → pmem_read before any pmem_write. l2_rdata=pmem_rdata, then the drain resumes.
- Assert reset during WRITE with count=3 → next cycle pmem_write=0, count=0, empty=1, evict_ready=1.
